// File: rtl/lut_neuron_bank_pipe.sv
`default_nettype none
// ============================================================================
// Module      : lut_neuron_bank_pipe
// Description : Bank of NUM_NEURONS programmable truth-table neurons sharing
//               one valid/ready stream. Each neuron looks its input slice up
//               in a runtime-writable distributed-RAM table. The result is
//               registered, backed by a one-entry skid buffer, and completed
//               output handshakes are tallied in a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_neuron_bank_pipe #(
  parameter int IN_BITS     = 8,
  parameter int OUT_BITS    = 2,
  parameter int NUM_NEURONS = 4,
  parameter int NSEL_BITS   = 2,
  parameter int COUNT_BITS  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_NEURONS*IN_BITS-1:0]  in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  input  logic                            cfg_we,
  input  logic [NSEL_BITS-1:0]            cfg_neuron,
  input  logic [IN_BITS-1:0]              cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_data,
  input  logic                            count_clr,
  output logic [COUNT_BITS-1:0]           vec_count
);

  localparam int                  DEPTH     = 1 << IN_BITS;
  localparam int                  VEC_W     = NUM_NEURONS * OUT_BITS;
  localparam logic [COUNT_BITS-1:0] COUNT_MAX = '1;

  // Combinational lookup result of every neuron for the current in_data.
  logic [VEC_W-1:0]      lut_rd;

  logic                  accept;
  logic                  handshake;

  logic                  out_valid_q, out_valid_d;
  logic [VEC_W-1:0]      out_data_q,  out_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [VEC_W-1:0]      skid_data_q,  skid_data_d;
  logic [COUNT_BITS-1:0] count_q,      count_d;

  // One table per neuron. The tables are never reset so a programmed network
  // survives rst. Out-of-range cfg_neuron values match no neuron and are
  // silently dropped. Because the lookup is combinational and captured at the
  // same edge as a write, a colliding lookup sees the pre-write value.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_neuron
      logic [OUT_BITS-1:0] tbl_q [DEPTH];

      // Table write port, active regardless of rst.
      always_ff @(posedge clk) begin
        if (cfg_we && (cfg_neuron == NSEL_BITS'(gi))) begin
          tbl_q[cfg_addr] <= cfg_data;
        end
      end

      assign lut_rd[gi*OUT_BITS +: OUT_BITS] = tbl_q[in_data[gi*IN_BITS +: IN_BITS]];
    end
  endgenerate

  // Ready only depends on registered state and rst, never on out_ready, so
  // the upstream path carries no combinational loop through this block.
  assign in_ready  = !skid_valid_q && !rst;
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign vec_count = count_q;

  // Output/skid routing: drain the skid first, otherwise place a new result
  // in the output register if it is free or draining, else park it in skid.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (handshake) begin
      if (skid_valid_q) begin
        // in_ready is low here, so no accept can coincide with this move.
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_data_d   = lut_rd;
      end else begin
        out_valid_d  = 1'b0;
      end
    end else if (!out_valid_q) begin
      if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = lut_rd;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = lut_rd;
    end
  end

  // Saturating handshake counter; an explicit clear beats an increment.
  always_comb begin
    count_d = count_q;
    if (count_clr) begin
      count_d = '0;
    end else if (handshake && (count_q != COUNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Pipeline and counter state registers; rst discards in-flight vectors.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      count_q      <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      count_q      <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lut_neuron_bank_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_lut_neuron_bank_pipe
// Description : Self-checking bench for lut_neuron_bank_pipe. A second
//               instance with a 4-bit counter shares all inputs to exercise
//               counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lut_neuron_bank_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        out_ready;
  logic        cfg_we;
  logic [2:0]  cfg_neuron;
  logic [7:0]  cfg_addr;
  logic [1:0]  cfg_data;
  logic        count_clr;

  logic        in_ready,   s_in_ready;
  logic [7:0]  out_data,   s_out_data;
  logic        out_valid,  s_out_valid;
  logic [15:0] vec_count;
  logic [3:0]  s_vec_count;

  lut_neuron_bank_pipe #(
    .IN_BITS(8), .OUT_BITS(2), .NUM_NEURONS(4), .NSEL_BITS(3), .COUNT_BITS(16)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .cfg_we(cfg_we), .cfg_neuron(cfg_neuron),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .count_clr(count_clr),
    .vec_count(vec_count)
  );

  lut_neuron_bank_pipe #(
    .IN_BITS(8), .OUT_BITS(2), .NUM_NEURONS(4), .NSEL_BITS(3), .COUNT_BITS(4)
  ) dut_s (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(s_in_ready), .out_data(s_out_data), .out_valid(s_out_valid),
    .out_ready(out_ready), .cfg_we(cfg_we), .cfg_neuron(cfg_neuron),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .count_clr(count_clr),
    .vec_count(s_vec_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: tables, in-flight vectors (at most two) and counters.
  logic [1:0] mtab [4][256];
  logic [7:0] q [$];
  int         mcount   = 0;
  int         mcount_s = 0;

  typedef struct {
    logic [31:0] din;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mlook(input logic [31:0] d);
    logic [7:0] r;
    for (int n = 0; n < 4; n++) r[n*2 +: 2] = mtab[n][d[n*8 +: 8]];
    return r;
  endfunction

  // One clock cycle: predict the edge from the model, clock, then compare.
  task automatic tick();
    logic       exp_rdy;
    logic       acc;
    logic [7:0] lk;
    #1;
    exp_rdy = !rst && (q.size() < 2);
    chk("in_ready", in_ready, exp_rdy);
    chk("s_in_ready", s_in_ready, exp_rdy);
    lk  = mlook(in_data);
    acc = in_valid && exp_rdy;
    if (rst) begin
      q.delete();
      mcount   = 0;
      mcount_s = 0;
    end else begin
      if (q.size() > 0 && out_ready) begin
        void'(q.pop_front());
        if (mcount < 65535) mcount++;
        if (mcount_s < 15) mcount_s++;
      end
      if (count_clr) begin
        mcount   = 0;
        mcount_s = 0;
      end
      if (acc) q.push_back(lk);
    end
    if (cfg_we && cfg_neuron < 3'd4) mtab[cfg_neuron][cfg_addr] = cfg_data;
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, q.size() > 0);
    chk("s_out_valid", s_out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0]);
      chk("s_out_data", s_out_data, q[0]);
    end
    chk("vec_count", vec_count, mcount);
    chk("s_vec_count", s_vec_count, mcount_s);
  endtask

  initial begin
    logic [31:0] d1, d2;
    logic [7:0]  e1, e2;

    // Hand-derived lookups for tables programmed as entry a of neuron n = (a+n)%4.
    vecs[0] = '{32'h03020100, 8'h88};
    vecs[1] = '{32'h00000000, 8'hE4};
    vecs[2] = '{32'hFFFFFFFF, 8'h93};
    vecs[3] = '{32'h55555555, 8'h39};
    vecs[4] = '{32'h0102FE7F, 8'h0F};

    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0; count_clr = 1'b0;

    // Reset state.
    tick();
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_vec_count", vec_count, 16'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Program every table entry.
    cfg_we = 1'b1;
    for (int n = 0; n < 4; n++) begin
      for (int a = 0; a < 256; a++) begin
        cfg_neuron = 3'(n);
        cfg_addr   = 8'(a);
        cfg_data   = 2'((a + n) % 4);
        tick();
      end
    end
    cfg_we = 1'b0;

    // Table-driven lookups, one per cycle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    foreach (vecs[i]) begin
      in_data = vecs[i].din;
      tick();
      chk($sformatf("vec_tbl[%0d]", i), out_data, vecs[i].exp);
    end

    // 100 random vectors back to back; counter starts from a clear.
    in_valid  = 1'b0;
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = $urandom;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("vec_count_100", vec_count, 16'd100);
    chk("s_vec_count_sat", s_vec_count, 4'd15);

    // Backpressure: output then skid fill, then drain in order.
    d1 = $urandom; d2 = $urandom;
    e1 = mlook(d1); e2 = mlook(d2);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = d1;
    tick();
    chk("bp_first_valid", out_valid, 1'b1);
    chk("bp_first_data", out_data, e1);
    in_data = d2;
    tick();
    chk("bp_skid_in_ready", in_ready, 1'b0);
    chk("bp_hold_data", out_data, e1);
    in_data = $urandom;
    tick();
    chk("bp_stall_data", out_data, e1);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    chk("bp_second_data", out_data, e2);
    chk("bp_second_valid", out_valid, 1'b1);
    chk("bp_ready_back", in_ready, 1'b1);
    tick();
    chk("bp_empty", out_valid, 1'b0);

    // Same-edge write and lookup of table[1][0x55]: old value then new value.
    cfg_we = 1'b1; cfg_neuron = 3'd1; cfg_addr = 8'h55; cfg_data = 2'd3;
    in_valid = 1'b1; in_data = 32'h0000_5500;
    tick();
    chk("rbw_old", out_data[3:2], 2'd2);
    cfg_we = 1'b0;
    tick();
    chk("rbw_new", out_data[3:2], 2'd3);

    // Writes to nonexistent neurons change nothing.
    in_valid = 1'b0;
    cfg_we   = 1'b1;
    for (int n = 4; n < 8; n++) begin
      cfg_neuron = 3'(n); cfg_addr = 8'h00; cfg_data = 2'(~n);
      tick();
    end
    cfg_we   = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h0;
    tick();
    chk("bad_neuron_ignored", out_data, 8'hE4);

    // Saturation of the narrow counter and clear-beats-increment.
    in_valid  = 1'b0;
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = $urandom;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("sat_count_16", vec_count, 16'd20);
    chk("sat_count_4", s_vec_count, 4'd15);
    in_valid = 1'b1;
    in_data  = $urandom;
    tick();
    in_valid  = 1'b0;
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    chk("clr_wins_16", vec_count, 16'd0);
    chk("clr_wins_4", s_vec_count, 4'd0);

    // Reset with output and skid full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = $urandom;
    tick();
    in_data = $urandom;
    tick();
    chk("full_before_rst", in_ready, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("rst_full_out_valid", out_valid, 1'b0);
    chk("rst_full_vec_count", vec_count, 16'd0);
    chk("rst_full_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    tick();
    chk("rst_full_release_ready", in_ready, 1'b1);
    d1 = $urandom;
    e1 = mlook(d1);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = d1;
    tick();
    chk("table_persists", out_data, e1);

    // Random mixed traffic with writes, clears and backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_data    = $urandom;
      out_ready  = ($urandom_range(0, 3) != 0);
      cfg_we     = ($urandom_range(0, 3) == 0);
      cfg_neuron = 3'($urandom_range(0, 7));
      cfg_addr   = 8'($urandom);
      cfg_data   = 2'($urandom);
      count_clr  = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
